// File: rtl/vip_frame_stream_gen.sv
// vip_frame_stream_gen - synthetic raster video source for the ISP pipeline.
//
// Emits one frame (or back-to-back frames when cont = 1) on the
// vsync/href/clken/8-bit pixel stream used by the ISP front end. All stream
// outputs are registered one cycle behind the raster counters.
//
// Optional feature macro: VIP_STREAM_GEN_MOVING_EN
//   defined   : pattern 3 is a moving diagonal ramp (x + y + frame count)
//   undefined : pattern 3 outputs 8'h00 and the ramp adder is not built
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request to begin a frame (ignored while running)
//   cont              1 = start the next frame immediately after each frame
//   pattern_sel       pattern select, latched at frame start
//   post_frame_vsync  frame sync, high for the first VSYNC_LINES lines
//   post_frame_href   active-line qualifier
//   post_frame_clken  pixel-valid strobe, one per CLKEN_DIV cycles within href
//   post_img_y        pixel value, 0 whenever clken is low
//   busy              frame in progress
//   frame_done        one-cycle pulse after the last cycle of a frame
//   frame_cnt         completed frame count, wraps 255 -> 0
module vip_frame_stream_gen #(
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned H_BLANK     = 160,
  parameter int unsigned VSYNC_LINES = 2,
  parameter int unsigned V_BACK      = 10,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned CLKEN_DIV   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [1:0] pattern_sel,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_y,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int unsigned ActLen     = IMG_W * CLKEN_DIV;
  localparam int unsigned LineLen    = ActLen + H_BLANK;
  localparam int unsigned FrameLines = VSYNC_LINES + V_BACK + IMG_H + V_FRONT;
  localparam int unsigned Act0       = VSYNC_LINES + V_BACK;
  localparam int unsigned ActEnd     = Act0 + IMG_H;

  localparam int unsigned HW = $clog2(LineLen);
  localparam int unsigned VW = $clog2(FrameLines);
  localparam int unsigned SW = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

  localparam logic [HW-1:0] HLast = HW'(LineLen - 1);
  localparam logic [VW-1:0] VLast = VW'(FrameLines - 1);
  localparam logic [SW-1:0] SLast = SW'(CLKEN_DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [SW-1:0]   s_q, s_d;   // cycle slot within the current pixel
  logic [HW-1:0]   x_q, x_d;   // pixel index within the line
  logic [1:0]      pat_q, pat_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            last_q, last_d;  // last counter state of a frame was just consumed

  logic            vsync_q, href_q, clken_q, busy_q, done_q;
  logic [7:0]      y_q, fcnt_q;

  // Next-state: FSM and raster counters
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    s_d     = s_q;
    x_d     = x_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    last_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        h_d = '0;
        v_d = '0;
        s_d = '0;
        x_d = '0;
        if (start) begin
          pat_d   = pattern_sel;
          state_d = StRun;
        end
      end
      StRun: begin
        if (h_q == HLast) begin
          h_d = '0;
          s_d = '0;
          x_d = '0;
          if (v_q == VLast) begin
            v_d    = '0;
            last_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            if (cont) begin
              pat_d = pattern_sel;
            end else begin
              state_d = StIdle;
            end
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
          if (s_q == SLast) begin
            s_d = '0;
            x_d = x_q + HW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      s_q     <= '0;
      x_q     <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      s_q     <= s_d;
      x_q     <= x_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Combinational stream terms from the current counter state
  logic       run;
  logic       vsync_c, href_c, clken_c;
  logic [7:0] x8, y8, pix_c;

  assign run     = (state_q == StRun);
  assign vsync_c = run && (32'(v_q) < VSYNC_LINES);
  assign href_c  = run && (32'(v_q) >= Act0) && (32'(v_q) < ActEnd) && (32'(h_q) < ActLen);
  assign clken_c = href_c && (s_q == '0);
  assign x8      = 8'(x_q);
  // Only meaningful inside the active rows, where v_q >= Act0.
  assign y8      = 8'(v_q - VW'(Act0));

`ifdef VIP_STREAM_GEN_MOVING_EN
  logic [7:0] ramp_c;
  assign ramp_c = x8 + y8 + cnt_q;
`else
  logic unused_y;
  assign unused_y = ^{y8[7:4], y8[2:1]};
`endif

  always_comb begin
    pix_c = 8'h00;
    unique case (pat_q)
      2'd0: pix_c = x8;
      2'd1: begin
        if (!x8[0] && !y8[0]) begin
          pix_c = 8'hC0;
        end else if (x8[0] && y8[0]) begin
          pix_c = 8'h40;
        end else begin
          pix_c = 8'h80;
        end
      end
      2'd2: pix_c = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
`ifdef VIP_STREAM_GEN_MOVING_EN
      2'd3: pix_c = ramp_c;
`else
      2'd3: pix_c = 8'h00;
`endif
      default: pix_c = 8'h00;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      y_q     <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= 8'h00;
    end else begin
      vsync_q <= vsync_c;
      href_q  <= href_c;
      clken_q <= clken_c;
      y_q     <= clken_c ? pix_c : 8'h00;
      // Rises with the accepted start; falls once the last frame cycle has left the outputs.
      busy_q  <= run || (state_d == StRun);
      done_q  <= last_q;
      fcnt_q  <= cnt_q;
    end
  end

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign post_img_y       = y_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign frame_cnt        = fcnt_q;

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
module tb_vip_frame_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cont, start3;
  logic [1:0] pattern_sel;
  logic       cont3;
  logic       vs, hr, ck, busy, done;
  logic [7:0] py, fcnt;
  logic       vs3, hr3, ck3, busy3, done3;
  logic [7:0] py3, fcnt3;

  vip_frame_stream_gen #(
    .IMG_W(8), .IMG_H(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1),
    .CLKEN_DIV(1)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .pattern_sel(pattern_sel),
    .post_frame_vsync(vs), .post_frame_href(hr), .post_frame_clken(ck), .post_img_y(py),
    .busy(busy), .frame_done(done), .frame_cnt(fcnt)
  );

  vip_frame_stream_gen #(
    .IMG_W(8), .IMG_H(10), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1),
    .CLKEN_DIV(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .cont(cont3), .pattern_sel(2'd2),
    .post_frame_vsync(vs3), .post_frame_href(hr3), .post_frame_clken(ck3), .post_img_y(py3),
    .busy(busy3), .frame_done(done3), .frame_cnt(fcnt3)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int pat, input int x, input int y, input int fc);
    case (pat)
      0: return 8'(x);
      1: begin
        if ((x % 2 == 0) && (y % 2 == 0)) return 8'hC0;
        if ((x % 2 == 1) && (y % 2 == 1)) return 8'h40;
        return 8'h80;
      end
      2: return (((x / 8) ^ (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
      default: begin
`ifdef VIP_STREAM_GEN_MOVING_EN
        return 8'((x + y + fc) % 256);
`else
        return 8'h00;
`endif
      end
    endcase
  endfunction

  // Scoreboards: expected pixels in raster order
  logic [7:0] q1[$];
  logic [7:0] q3[$];

  task automatic push_frame(input int which, input int pat, input int h, input int fc);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (which == 1) q1.push_back(model(pat, x, y, fc));
        else q3.push_back(model(pat, x, y, fc));
      end
    end
  endtask

  always @(negedge clk) begin
    if (ck) begin
      if (q1.size() == 0) begin
        checks++;
        fails++;
        $error("FAIL px1_unexpected: got %0h expected no pixel", py);
      end else begin
        check("px1", {24'd0, py}, {24'd0, q1.pop_front()});
      end
    end else begin
      check("px1_zero", {24'd0, py}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (ck3) begin
      if (q3.size() == 0) begin
        checks++;
        fails++;
        $error("FAIL px3_unexpected: got %0h expected no pixel", py3);
      end else begin
        check("px3", {24'd0, py3}, {24'd0, q3.pop_front()});
      end
    end else begin
      check("px3_zero", {24'd0, py3}, 32'd0);
    end
  end

  int   n_vs, n_hr, n_ck, n_busy;
  int   done_t[$];
  logic vs_log  [0:511];
  logic busy_log[0:511];

  // Observe u_dut for ncyc output cycles; t = 1 is the first frame cycle.
  task automatic watch(input int ncyc, input int pulse_t, input int drop_cont_t);
    n_vs = 0; n_hr = 0; n_ck = 0; n_busy = 0;
    done_t.delete();
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      if (vs) n_vs++;
      if (hr) n_hr++;
      if (ck) n_ck++;
      if (busy) n_busy++;
      if (done) done_t.push_back(t);
      vs_log[t]   = vs;
      busy_log[t] = busy;
      start = (t == pulse_t);
      if (t == drop_cont_t) cont = 1'b0;
    end
  endtask

  task automatic do_start(input logic [1:0] pat);
    @(negedge clk);
    pattern_sel = pat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("vs_not_yet", {31'd0, vs}, 32'd0);
  endtask

  initial begin
    int last_ck, run_len;
    logic prev_hr;
    int n_hr3, n_ck3, n_done3, done3_t;

    rst = 1'b1; start = 1'b0; cont = 1'b0; pattern_sel = 2'd0; start3 = 1'b0; cont3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vs", {31'd0, vs}, 32'd0);
    check("rst_hr", {31'd0, hr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fcnt", {24'd0, fcnt}, 32'd0);
    check("rst_busy3", {31'd0, busy3}, 32'd0);
    rst = 1'b0;

    // Single frame, horizontal ramp
    push_frame(1, 0, 4, 0);
    do_start(2'd0);
    watch(90, 0, 0);
    check("t1_vsync_cycles", n_vs, 12);
    check("t1_href_cycles", n_hr, 32);
    check("t1_clken_count", n_ck, 32);
    check("t1_vsync_first", {31'd0, vs_log[1]}, 32'd1);
    check("t1_busy_cycles", n_busy, 84);
    check("t1_busy_last", {31'd0, busy_log[84]}, 32'd1);
    check("t1_busy_fall", {31'd0, busy_log[85]}, 32'd0);
    check("t1_done_count", done_t.size(), 1);
    if (done_t.size() > 0) check("t1_done_time", done_t[0], 85);
    check("t1_fcnt", {24'd0, fcnt}, 32'd1);
    check("t1_sb_empty", q1.size(), 0);

    // Pattern 3 on the second frame
    push_frame(1, 3, 4, 1);
    do_start(2'd3);
    watch(90, 0, 0);
    check("t2_done_count", done_t.size(), 1);
    check("t2_fcnt", {24'd0, fcnt}, 32'd2);
    check("t2_sb_empty", q1.size(), 0);

    // Bayer RGGB
    push_frame(1, 1, 4, 2);
    do_start(2'd1);
    watch(90, 0, 0);
    check("t3_clken_count", n_ck, 32);
    check("t3_fcnt", {24'd0, fcnt}, 32'd3);
    check("t3_sb_empty", q1.size(), 0);

    // Reset mid-frame (row 0 active, a few pixels out)
    push_frame(1, 0, 4, 3);
    do_start(2'd0);
    watch(28, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_vs", {31'd0, vs}, 32'd0);
    check("mid_rst_hr", {31'd0, hr}, 32'd0);
    check("mid_rst_ck", {31'd0, ck}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_fcnt", {24'd0, fcnt}, 32'd0);
    rst = 1'b0;
    q1.delete();
    watch(100, 0, 0);
    check("post_rst_no_done", done_t.size(), 0);
    check("post_rst_idle_vs", n_vs, 0);
    check("post_rst_fcnt", {24'd0, fcnt}, 32'd0);

    // Continuous mode, 3 frames, stray start mid-frame
    push_frame(1, 3, 4, 0);
    push_frame(1, 3, 4, 1);
    push_frame(1, 3, 4, 2);
    cont = 1'b1;
    do_start(2'd3);
    watch(260, 40, 200);
    check("cont_done_count", done_t.size(), 3);
    if (done_t.size() == 3) begin
      check("cont_done0", done_t[0], 85);
      check("cont_done1", done_t[1], 169);
      check("cont_done2", done_t[2], 253);
    end
    check("cont_vs_gap_before", {31'd0, vs_log[84]}, 32'd0);
    check("cont_vs_zero_gap", {31'd0, vs_log[85]}, 32'd1);
    check("cont_vsync_cycles", n_vs, 36);
    check("cont_clken_count", n_ck, 96);
    check("cont_busy_cycles", n_busy, 252);
    check("cont_busy_fall", {31'd0, busy_log[253]}, 32'd0);
    check("cont_fcnt", {24'd0, fcnt}, 32'd3);
    check("cont_sb_empty", q1.size(), 0);

    // CLKEN_DIV = 3 instance, 8x8 checker
    push_frame(3, 2, 10, 0);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("d3_busy_rise", {31'd0, busy3}, 32'd1);
    n_hr3 = 0; n_ck3 = 0; n_done3 = 0; done3_t = 0;
    last_ck = 0; run_len = 0; prev_hr = 1'b0;
    for (int t = 1; t <= 370; t++) begin
      @(negedge clk);
      if (hr3) begin
        n_hr3++;
        run_len++;
      end
      if (ck3) n_ck3++;
      if (done3) begin
        n_done3++;
        done3_t = t;
      end
      if (hr3 && !prev_hr) check("d3_clken_on_href_rise", {31'd0, ck3}, 32'd1);
      if (ck3 && prev_hr) check("d3_clken_spacing", t - last_ck, 3);
      if (!hr3 && prev_hr) begin
        check("d3_href_len", run_len, 24);
        run_len = 0;
      end
      if (ck3) last_ck = t;
      prev_hr = hr3;
    end
    check("d3_href_cycles", n_hr3, 240);
    check("d3_clken_count", n_ck3, 80);
    check("d3_done_count", n_done3, 1);
    check("d3_done_time", done3_t, 365);
    check("d3_fcnt", {24'd0, fcnt3}, 32'd1);
    check("d3_sb_empty", q3.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
